// File: rtl/divider_defs.sv
// Shared definitions for the clock-division path: controller state encodings
// and default sizing, reused by other slow-rate clock consumers.
package divider_defs;

    localparam int          DEF_WIDTH = 32;
    localparam int unsigned DEF_DIV   = 50000000;  // 100 MHz board clock down to a 1 Hz half-period

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } div_state_e;

endpackage

// File: rtl/half_period_counter.sv
// Counts clk_in cycles within one half-period and flags the last cycle of it.
module half_period_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             terminal
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // limit is never zero: zero divisors are rejected before they reach here
    assign terminal = enable && (count == limit - ONE);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= terminal ? '0 : count + ONE;
        end
    end

endmodule

// File: rtl/divider_ctrl.sv
// Run/stop/step controller and glitch-free rate scheduler: divisor changes
// land only on half-period boundaries so slow consumers never see a runt pulse.
module divider_ctrl
    import divider_defs::*;
#(
    parameter int               WIDTH       = DEF_WIDTH,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(DEF_DIV)
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             tick,
    output logic             clk_out,
    output logic             busy,
    output logic [WIDTH-1:0] div_active
);

    div_state_e       state;
    logic             pend_valid;
    logic [WIDTH-1:0] pend_div;
    logic             counting;
    logic             terminal;
    logic [WIDTH-1:0] count;

    assign counting  = (state == ST_RUN) || (state == ST_STEP);
    assign cfg_ready = !pend_valid;

    half_period_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk_in   (clk_in),
        .reset    (reset),
        .enable   (counting),
        .clear    (!counting),
        .limit    (div_active),
        .count    (count),
        .terminal (terminal)
    );

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state      <= ST_STOP;
            tick       <= 1'b0;
            clk_out    <= 1'b0;
            busy       <= 1'b0;
            cfg_err    <= 1'b0;
            pend_valid <= 1'b0;
            pend_div   <= '0;
            div_active <= DEFAULT_DIV;
        end else begin
            tick    <= terminal;
            busy    <= (state != ST_STOP);
            cfg_err <= cfg_valid && !pend_valid && (cfg_div == '0);
            if (terminal) begin
                clk_out <= !clk_out;
            end

            case (state)
                ST_STOP: begin
                    if (run) begin
                        state <= ST_RUN;
                    end else if (step) begin
                        state <= ST_STEP;
                    end
                end
                ST_RUN: begin
                    // run is only sampled at the boundary, so a half-period is never cut short
                    if (terminal && !run) begin
                        state <= ST_STOP;
                    end
                end
                ST_STEP: begin
                    if (terminal) begin
                        state <= ST_STOP;
                    end
                end
                default: state <= ST_STOP;
            endcase

            // Apply and accept are mutually exclusive: accept needs an empty slot
            if (pend_valid) begin
                if (terminal || (state == ST_STOP)) begin
                    div_active <= pend_div;
                    pend_valid <= 1'b0;
                end
            end else if (cfg_valid && (cfg_div != '0)) begin
                pend_div   <= cfg_div;
                pend_valid <= 1'b1;
            end
        end
    end

endmodule

// File: doc/divider_ctrl.md
# divider_ctrl

Run/stop/step controller and glitch-free rate scheduler for the project's clock-division path. It owns a half-period counter, produces a one-cycle `tick` enable and a 50%-duty `clk_out`, and accepts new divisor values over a valid/ready handshake. New divisors take effect only at period boundaries, so downstream display and FSM logic never sees a runt pulse. It sits between the board clock and every slow-rate consumer: counters, display multiplexing and game-state timing.

## Interface
Parameters:
- `WIDTH`, 32, width of divisor and counter
- `DEFAULT_DIV`, 50000000, half-period length in `clk_in` cycles after reset (100 MHz to 1 Hz)

Ports:
- `clk_in`  in  1  system clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-low; low forces reset state immediately
- `run`  in  1  level; high requests free-running output
- `step`  in  1  single-cycle pulse; requests exactly one half-period from STOP
- `cfg_valid`  in  1  new divisor offered
- `cfg_div`  in  WIDTH  half-period length in cycles, legal range 1..2^WIDTH-1
- `cfg_ready`  out  1  controller can accept a divisor
- `cfg_err`  out  1  one-cycle pulse: accepted `cfg_div` was 0 and was discarded
- `tick`  out  1  one-cycle pulse at each half-period boundary
- `clk_out`  out  1  toggles at each `tick`
- `busy`  out  1  state is not STOP
- `div_active`  out  WIDTH  divisor currently applied

## Operation
- Reset values: state STOP, counter 0, `clk_out` 0, `tick` 0, `cfg_ready` 1, `cfg_err` 0, `busy` 0, `div_active` = `DEFAULT_DIV`, pending slot empty.
- States:
  - STOP: counter held at 0 and `clk_out` held.
    - `run`=1 → RUN.
    - Else `step`=1 → STEP.
    - `run` and `step` both high: `run` wins.
  - RUN: counter increments each cycle. At terminal (counter == `div_active`-1): counter → 0, `clk_out` toggles, `tick` = 1. If `run`=0 at the terminal edge → STOP, else stay in RUN. Dropping `run` mid-period never truncates a half-period. `step` is ignored.
  - STEP: counts like RUN. At terminal: tick, toggle, → STOP regardless of `run`.
- Config handshake:
  - Transfer occurs on an edge with `cfg_valid` & `cfg_ready`.
  - `cfg_ready` = pending slot empty.
  - A nonzero `cfg_div` is loaded into the pending slot and `cfg_ready` drops.
  - `cfg_div` = 0 is consumed: `cfg_err` pulses the next cycle, the slot stays empty and `cfg_ready` stays high.
- Pending apply:
  - In RUN/STEP, applied on the terminal edge: `div_active` ← pending, slot cleared, `cfg_ready` high next cycle. The next half-period uses the new value.
  - In STOP, applied on the edge after the transfer.
  - A transfer on the same edge as a terminal is not applied at that terminal. It waits for the next one.
- Counter compare uses `div_active` only, never the pending value. Counter width = WIDTH, and it never exceeds `div_active`-1.
- Reset asserted mid-period: all state returns to reset values immediately, and the pending value is lost.

## Timing
- STOP→RUN on edge E0, counter = 0. The first `tick`/toggle is registered at edge E0+`div_active`, then every `div_active` cycles.
- `div_active` = 1: `tick` held high continuously in RUN, and `clk_out` toggles every cycle.
- `tick` and the `clk_out` edge are registered together, so `tick` is high during the first cycle of the new `clk_out` level.
- `busy` is registered from state: high the cycle after leaving STOP, low the cycle after the final tick.
- Config latency:
  - In STOP: 1 edge from transfer to `div_active` update.
  - In RUN: until the next terminal edge, at most `div_active` cycles.

## Structure
- Shared header `divider_defs` holds the state encodings (STOP=2'd0, RUN=2'd1, STEP=2'd2), the default WIDTH and DEFAULT_DIV, and is reused by other clock consumers.
- One sub-module is natural: `half_period_counter`.
  - Inputs: enable, clear, `limit`.
  - Outputs: `count`, `terminal`.
  - The controller FSM, config slot and `clk_out`/`tick` registers stay in `divider_ctrl`.
- Unused state encoding 2'd3 recovers to STOP.

## Test plan
- Reset → `clk_out`=0, `busy`=0, `cfg_ready`=1, `div_active`=DEFAULT_DIV; override DEFAULT_DIV=4 for sim.
- DIV=4, `run` high at E0 → ticks at E4, E8, E12; `clk_out` period 8 cycles, 50% duty.
- `step` pulse in STOP, DIV=3 → one tick at E3, then STOP with `busy`=0; a second `step` while in STEP is ignored.
- RUN DIV=4, transfer `cfg_div`=2 at E5 → `cfg_ready` low; ticks at E8 (old value), E10, E12; `cfg_ready` high after E8.
- `cfg_div`=0 offered → `cfg_err` pulses 1 cycle, `div_active` unchanged, `cfg_ready` remains 1.
- `run` dropped mid-period at E6 (DIV=4) → final tick at E8, then STOP; `reset` low mid-period → all outputs return to reset values asynchronously.
